bp_io_wormhole_deserializer: RTL

- Downstream consumer of the IO tile's io_cmd wormhole link.
- Accepts ready/valid-and wormhole flits and reassembles them into one wide packet: a header flit plus len body flits.
- Presents the packet on a valid/yumi interface to the IO endpoint logic.
- Single clock domain (IO clock). Buffers exactly one packet.

---
 rtl/bp_me_pkg.sv | 33 +++
 rtl/bp_io_flit_slot_mem.sv | 53 +++++
 rtl/bp_io_wormhole_deserializer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bp_me_pkg.sv
// Shared types for the IO wormhole deserializer.
//   bp_io_deser_state_e     : e_ready / e_body / e_full FSM states.
//   BP_IO_WORMHOLE_HEADER_S : macro declaring the header struct {len, cord} for given field widths.
//   bp_io_pkt_width()       : derived width of a reassembled packet.
// No ports; imported by the deserializer top and its slot memory.

`ifndef BP_IO_WORMHOLE_HEADER_S_DEFINED
`define BP_IO_WORMHOLE_HEADER_S_DEFINED
// Header occupies the low bits of a flit: cord in the LSBs, len directly above it.
`define BP_IO_WORMHOLE_HEADER_S(cord_w, len_w) \
  typedef struct packed { \
    logic [len_w-1:0]  len; \
    logic [cord_w-1:0] cord; \
  } bp_io_wormhole_header_s
`endif

package bp_me_pkg;

  typedef enum logic [1:0] {
    e_ready,
    e_body,
    e_full
  } bp_io_deser_state_e;

  function automatic int unsigned bp_io_pkt_width(input int unsigned flit_w,
                                                  input int unsigned max_flits);
    return flit_w * max_flits;
  endfunction

  // Packet width for the default configuration (64-bit flits, 8 slots).
  localparam int unsigned bp_io_pkt_width_gp = bp_io_pkt_width(64, 8);

endpackage

// File: rtl/bp_io_flit_slot_mem.sv
// Register array of max_flits_p flit slots, written one slot at a time.
// A write with clr_i set also zeroes every slot not being written, so a header
// write leaves the unused tail of the packet reading zero.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset (all slots to zero)
//   w_v_i          : write enable
//   clr_i          : zero all slots other than the written one
//   w_idx_i        : slot index to write
//   w_data_i       : flit to write
//   data_o         : all slots concatenated, slot k at [k*flit_width_p +: flit_width_p]

module bp_io_flit_slot_mem
  import bp_me_pkg::*;
#(
  parameter int unsigned flit_width_p = 64,
  parameter int unsigned max_flits_p  = 8,
  localparam int unsigned idx_width_lp = (max_flits_p > 1) ? $clog2(max_flits_p) : 1,
  localparam int unsigned pkt_width_lp = bp_io_pkt_width(flit_width_p, max_flits_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    w_v_i,
  input  logic                    clr_i,
  input  logic [idx_width_lp-1:0] w_idx_i,
  input  logic [flit_width_p-1:0] w_data_i,
  output logic [pkt_width_lp-1:0] data_o
);

  logic [max_flits_p-1:0]                   w_en;
  logic [max_flits_p-1:0][flit_width_p-1:0] slot_q;

  always_comb begin
    w_en = '0;
    if (w_v_i) w_en[w_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot_q <= '0;
    end else begin
      for (int k = 0; k < int'(max_flits_p); k++) begin
        if (w_en[k]) begin
          slot_q[k] <= w_data_i;
        end else if (clr_i) begin
          slot_q[k] <= '0;
        end
      end
    end
  end

  assign data_o = slot_q;

endmodule

// File: rtl/bp_io_wormhole_deserializer.sv
// Reassembles an io_cmd wormhole (header + len body flits) into one wide packet and
// presents it on a valid/yumi interface. Buffers exactly one packet.
// Body flits beyond max_flits_p total are accepted but dropped, and pkt_err_o is set.
// Optional feature: define BP_IO_DESER_OVERLAP_EN to accept the next header in the
// same cycle the current packet is taken (adds a yumi_i -> ready_and_o path).
// Ports:
//   io_clk_i, io_reset_i : clock, asynchronous active-high reset
//   flit_i, v_i          : incoming flit and its valid
//   ready_and_o          : flit accepted when v_i & ready_and_o
//   pkt_o                : packet, flit k at [k*flit_width_p +: flit_width_p]
//   len_o                : header len field of the held packet
//   pkt_err_o            : packet was oversize and truncated
//   v_o, yumi_i          : packet valid / consumer takes it

module bp_io_wormhole_deserializer
  import bp_me_pkg::*;
#(
  parameter int unsigned flit_width_p = 64,
  parameter int unsigned cord_width_p = 7,
  parameter int unsigned len_width_p  = 4,
  parameter int unsigned max_flits_p  = 8,
  localparam int unsigned pkt_width_lp = bp_io_pkt_width(flit_width_p, max_flits_p)
) (
  input  logic                    io_clk_i,
  input  logic                    io_reset_i,
  input  logic [flit_width_p-1:0] flit_i,
  input  logic                    v_i,
  output logic                    ready_and_o,
  output logic [pkt_width_lp-1:0] pkt_o,
  output logic [len_width_p-1:0]  len_o,
  output logic                    pkt_err_o,
  output logic                    v_o,
  input  logic                    yumi_i
);

  // One extra bit so the count reaches len+1 without wrapping at the maximum len.
  localparam int unsigned cnt_width_lp = len_width_p + 1;
  localparam int unsigned idx_width_lp = (max_flits_p > 1) ? $clog2(max_flits_p) : 1;

  `BP_IO_WORMHOLE_HEADER_S(cord_width_p, len_width_p);

  bp_io_wormhole_header_s hdr;
  assign hdr = flit_i[cord_width_p+len_width_p-1:0];

  // Destination cord travels in slot 0 but is not interpreted here.
  logic unused_cord;
  assign unused_cord = ^hdr.cord;

  bp_io_deser_state_e      state_q, state_d;
  logic [cnt_width_lp-1:0] cnt_q, cnt_d;
  logic [len_width_p-1:0]  len_q, len_d;
  logic                    err_q, err_d;

  logic                    start_hdr;
  logic                    mem_w_v;
  logic                    mem_clr;
  logic [idx_width_lp-1:0] mem_idx;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    err_d       = err_q;
    ready_and_o = 1'b0;
    v_o         = 1'b0;
    start_hdr   = 1'b0;
    mem_w_v     = 1'b0;
    mem_clr     = 1'b0;
    mem_idx     = '0;

    unique case (state_q)
      e_ready: begin
        ready_and_o = 1'b1;
        start_hdr   = v_i;
      end
      e_body: begin
        ready_and_o = 1'b1;
        if (v_i) begin
          if (32'(cnt_q) < max_flits_p) begin
            mem_w_v = 1'b1;
            mem_idx = cnt_q[idx_width_lp-1:0];
          end else begin
            err_d = 1'b1;
          end
          cnt_d = cnt_q + cnt_width_lp'(1);
          if (cnt_q == {1'b0, len_q}) state_d = e_full;
        end
      end
      e_full: begin
        v_o = 1'b1;
`ifdef BP_IO_DESER_OVERLAP_EN
        ready_and_o = yumi_i;
        start_hdr   = yumi_i & v_i;
`endif
        if (yumi_i) state_d = e_ready;
      end
      default: state_d = e_ready;
    endcase

    // Header load; overrides the e_full -> e_ready step when overlapping.
    if (start_hdr) begin
      mem_w_v = 1'b1;
      mem_clr = 1'b1;
      mem_idx = '0;
      len_d   = hdr.len;
      err_d   = 1'b0;
      cnt_d   = cnt_width_lp'(1);
      state_d = (hdr.len == '0) ? e_full : e_body;
    end
  end

  always_ff @(posedge io_clk_i or posedge io_reset_i) begin
    if (io_reset_i) begin
      state_q <= e_ready;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  bp_io_flit_slot_mem #(
    .flit_width_p(flit_width_p),
    .max_flits_p (max_flits_p)
  ) u_slot_mem (
    .clk_i   (io_clk_i),
    .reset_i (io_reset_i),
    .w_v_i   (mem_w_v),
    .clr_i   (mem_clr),
    .w_idx_i (mem_idx),
    .w_data_i(flit_i),
    .data_o  (pkt_o)
  );

  assign len_o     = len_q;
  assign pkt_err_o = err_q;

  yumi_only_when_valid: assert property (@(posedge io_clk_i) disable iff (io_reset_i)
    yumi_i |-> v_o);
  v_i_known: assert property (@(posedge io_clk_i) disable iff (io_reset_i)
    !$isunknown(v_i));

endmodule
